updown_counter_param: RTL and testbench
=======================================

// Module: updown_counter_param
// PURPOSE
//  Parametrised up/down counter: programmable step, saturate or wrap at bounds, parallel load.
//  Out-of-range load drives an explicit error state.
//  Registered terminal-count pulse for chaining or event generation.
//  Drop-in successor for the lab fixed 4-bit 0..12 counter; the default config matches its counting range.
// PARAMETERS
//  WIDTH    4   counter width; out range 0..MAX_VAL, ERR_VAL = {WIDTH{1'b1}}
//  MAX_VAL  12  upper count bound; legal iff MAX_VAL < 2**WIDTH-1 (else elaboration $error)
//  STEP_W   2   step width; legal iff 2**STEP_W-1 <= MAX_VAL (else elaboration $error)
//  WRAP     0   0 = saturate at bounds, 1 = wrap modulo (MAX_VAL+1)
// PORTS
//  clk    in   1         clock, posedge
//  rst    in   1         reset, asynchronous, active-high
//  en     in   1         1 = update on clk edge, 0 = hold everything (tc forced 0)
//  dir    in   1         1 = count up, 0 = count down
//  load   in   1         parallel load request (priority over counting)
//  step   in   STEP_W    count increment/decrement magnitude; 0 = no-op
//  data   in   WIDTH+2   load value, unsigned, wider than out so overrange is detectable
//  out    out  WIDTH     registered count value, or ERR_VAL in error state
//  err    out  1         registered, 1 while in ERROR state
//  tc     out  1         registered one-cycle pulse, bound reached/crossed
// BEHAVIOUR
//  Reset: rst=1 -> out=0, err=0, tc=0 immediately (async); state=COUNT.
//  All updates on posedge clk; priority rst > !en > load > count.
//  FSM states: COUNT, ERROR.
//   COUNT --load, data>MAX_VAL--> ERROR: out=ERR_VAL, err=1.
//   ERROR --load, data<=MAX_VAL--> COUNT: out=data[WIDTH-1:0], err=0.
//   ERROR: counting ignored, out holds ERR_VAL; exit only via valid load or rst.
//  Load (en=1, load=1): compare the full WIDTH+2-bit data against MAX_VAL; tc=0.
//  Count (en=1, load=0, COUNT): compute in WIDTH+1 bits, no silent truncation.
//   Up, out+step <= MAX_VAL: out += step.
//   Up, out+step > MAX_VAL, WRAP=0: out=MAX_VAL.
//   Up, out+step > MAX_VAL, WRAP=1: out=out+step-(MAX_VAL+1).
//   Down, step <= out: out -= step.
//   Down, step > out, WRAP=0: out=0.
//   Down, step > out, WRAP=1: out=out+(MAX_VAL+1)-step.
//   A single correction always suffices because step <= MAX_VAL.
//  tc=1 for exactly the cycle after an edge where:
//   up with out+step > MAX_VAL, or out+step == MAX_VAL with step != 0; or
//   down with step > out, or step == out with step != 0.
//  Saturated counter with repeated step != 0 at the bound: tc re-asserts every cycle.
//  step=0: out unchanged, tc=0.
//  en=0: out, err and state hold; tc=0; load ignored.
//  Latency: one clk edge from inputs to out/err/tc. No combinational in->out paths.
//  rst mid-operation (any state, any phase): outputs clear asynchronously. Counting resumes at the first posedge after rst falls.
// STRUCTURE
//  Shared package ctr_pkg:
//   typedef enum {ST_COUNT, ST_ERROR}
//   localparam MODE_SAT=0, MODE_WRAP=1
//  Sub-module ctr_next_calc: combinational next-value/tc-hit from out, step, dir, WRAP, MAX_VAL.
//  Top: FSM, load range check, output registers.
// TESTING  (WIDTH=4, MAX_VAL=12, STEP_W=2 unless noted)
//  T1: out=7, rst=1 between edges -> out=0, err=0, tc=0 before next edge; then up step=1 -> 1.
//  T2: load data=9 -> out=9; load data=13 -> out=15, err=1; up step=1 -> out=15;
//      load data=3 -> out=3, err=0.
//  T3 (WRAP=0): out=11, up step=3 -> out=12, tc=1; same again -> 12, tc=1; step=0 -> tc=0.
//  T4 (WRAP=1): out=11, up step=3 -> out=1, tc=1; down step=2 -> out=12, tc=1; down step=1 -> 11, tc=0.
//  T5: en=0 with load=1, data=5 -> out, err unchanged, tc=0;
//      load=1 and dir=1, step=2 same edge -> out=data (load wins).
//  T6: load data=63 (max 6-bit) -> ERROR, out=15; rst -> out=0, err=0.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared types and constants for the parametrised up/down counter.
package ctr_pkg;

    // Counter FSM states.
    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_ERROR = 1'b1
    } ctr_state_e;

    // Bound behaviour selectors for the WRAP parameter.
    localparam int MODE_SAT  = 0;
    localparam int MODE_WRAP = 1;

    // Even parity of a 6-bit load word, kept for integrity extensions.
    function automatic logic parity6(input logic [5:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ctr_next_calc.sv
// Combinational next-count and terminal-count detection for COUNT state.
// Arithmetic is carried in WIDTH+1 bits so bound crossings are never lost
// to truncation; a single correction suffices because step <= MAX_VAL.
module ctr_next_calc
    import ctr_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 12,
    parameter int STEP_W  = 2,
    parameter int WRAP    = MODE_SAT
) (
    input  logic [WIDTH-1:0]  i_cur,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_dir,
    output logic [WIDTH-1:0]  o_nxt,
    output logic              o_hit
);

    localparam logic [WIDTH:0] LP_MAX = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] LP_MOD = (WIDTH+1)'(MAX_VAL + 1);

    logic [WIDTH:0] w_cur_ext;
    logic [WIDTH:0] w_step_ext;
    logic [WIDTH:0] w_sum;
    logic           w_step_nz;

    assign w_cur_ext  = {1'b0, i_cur};
    assign w_step_ext = (WIDTH+1)'(i_step);
    assign w_sum      = w_cur_ext + w_step_ext;
    assign w_step_nz  = (i_step != {STEP_W{1'b0}});

    // Select next value and bound-hit flag for the requested direction.
    always_comb begin
        o_nxt = i_cur;
        o_hit = 1'b0;
        if (i_dir) begin
            if (w_sum > LP_MAX) begin
                o_hit = 1'b1;
                if (WRAP == MODE_WRAP) begin
                    o_nxt = WIDTH'(w_sum - LP_MOD);
                end else begin
                    o_nxt = WIDTH'(LP_MAX);
                end
            end else begin
                o_nxt = WIDTH'(w_sum);
                o_hit = (w_sum == LP_MAX) && w_step_nz;
            end
        end else begin
            if (w_step_ext > w_cur_ext) begin
                o_hit = 1'b1;
                if (WRAP == MODE_WRAP) begin
                    o_nxt = WIDTH'((w_cur_ext + LP_MOD) - w_step_ext);
                end else begin
                    o_nxt = {WIDTH{1'b0}};
                end
            end else begin
                o_nxt = WIDTH'(w_cur_ext - w_step_ext);
                o_hit = (w_step_ext == w_cur_ext) && w_step_nz;
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable step, saturate or wrap
// at the bounds, range-checked parallel load with an explicit error state,
// and a registered terminal-count pulse.
module updown_counter_param
    import ctr_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 12,
    parameter int STEP_W  = 2,
    parameter int WRAP    = MODE_SAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic              load,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH+1:0]  data,
    output logic [WIDTH-1:0]  out,
    output logic              err,
    output logic              tc
);

    localparam logic [WIDTH-1:0] ERR_VAL      = {WIDTH{1'b1}};
    localparam logic [WIDTH+1:0] LP_MAX_DATA  = (WIDTH+2)'(MAX_VAL);

    // ERR_VAL must stay outside the counting range, and a step must never
    // need more than one modulo correction.
    if (MAX_VAL >= (2**WIDTH) - 1) begin : g_bad_max
        $error("updown_counter_param: MAX_VAL must be below 2**WIDTH-1");
    end
    if ((2**STEP_W) - 1 > MAX_VAL) begin : g_bad_step
        $error("updown_counter_param: 2**STEP_W-1 must not exceed MAX_VAL");
    end

    ctr_state_e       r_state;
    ctr_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_tc;
    logic             w_tc_nxt;

    logic [WIDTH-1:0] w_calc_nxt;
    logic             w_calc_hit;
    logic             w_load_ok;

    assign w_load_ok = (data <= LP_MAX_DATA);

    ctr_next_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W),
        .WRAP    (WRAP)
    ) u_next_calc (
        .i_cur  (r_out),
        .i_step (step),
        .i_dir  (dir),
        .o_nxt  (w_calc_nxt),
        .o_hit  (w_calc_hit)
    );

    // Next state and outputs: hold on !en, then load, then count.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_err_nxt   = r_err;
        w_tc_nxt    = 1'b0;
        if (!en) begin
            w_state_nxt = r_state;
            w_out_nxt   = r_out;
            w_err_nxt   = r_err;
        end else if (load) begin
            if (w_load_ok) begin
                w_state_nxt = ST_COUNT;
                w_out_nxt   = data[WIDTH-1:0];
                w_err_nxt   = 1'b0;
            end else begin
                w_state_nxt = ST_ERROR;
                w_out_nxt   = ERR_VAL;
                w_err_nxt   = 1'b1;
            end
        end else begin
            case (r_state)
                ST_COUNT: begin
                    w_out_nxt = w_calc_nxt;
                    w_tc_nxt  = w_calc_hit;
                    w_err_nxt = 1'b0;
                end
                ST_ERROR: begin
                    w_out_nxt = ERR_VAL;
                    w_err_nxt = 1'b1;
                end
                default: begin
                    // Unknown encoding: park in the error state.
                    w_state_nxt = ST_ERROR;
                    w_out_nxt   = ERR_VAL;
                    w_err_nxt   = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_COUNT;
            r_out   <= {WIDTH{1'b0}};
            r_err   <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_err   <= w_err_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign out = r_out;
    assign err = r_err;
    assign tc  = r_tc;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed-vector bench for updown_counter_param: one saturating and one
// wrapping instance (WIDTH=4, MAX_VAL=12, STEP_W=2).
module tb_updown_counter_param;
    import ctr_pkg::*;

    typedef struct {
        int         sel;    // 0 = saturating DUT, 1 = wrapping DUT
        logic       en;
        logic       dir;
        logic       load;
        logic [1:0] step;
        logic [5:0] data;
        logic [3:0] out;
        logic       err;
        logic       tc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_en = 1'b0, s_dir = 1'b0, s_load = 1'b0;
    logic [1:0] s_step = 2'd0;
    logic [5:0] s_data = 6'd0;
    logic [3:0] s_out;
    logic       s_err, s_tc;
    logic       w_en = 1'b0, w_dir = 1'b0, w_load = 1'b0;
    logic [1:0] w_step = 2'd0;
    logic [5:0] w_data = 6'd0;
    logic [3:0] w_out;
    logic       w_err, w_tc;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MAX_VAL(12), .STEP_W(2), .WRAP(MODE_SAT)) u_sat (
        .clk(clk), .rst(rst), .en(s_en), .dir(s_dir), .load(s_load),
        .step(s_step), .data(s_data), .out(s_out), .err(s_err), .tc(s_tc)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(12), .STEP_W(2), .WRAP(MODE_WRAP)) u_wrap (
        .clk(clk), .rst(rst), .en(w_en), .dir(w_dir), .load(w_load),
        .step(w_step), .data(w_data), .out(w_out), .err(w_err), .tc(w_tc)
    );

    function automatic vec_t mk(input int sel, input logic en, input logic dir,
                                input logic load, input int step, input int data,
                                input int out, input logic err, input logic tc);
        vec_t v;
        v.sel = sel; v.en = en; v.dir = dir; v.load = load;
        v.step = 2'(step); v.data = 6'(data); v.out = 4'(out);
        v.err = err; v.tc = tc;
        return v;
    endfunction

    task automatic chk(input string tag, input string fld, input int act, input int exp);
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d", tag, fld, act, exp);
        end
    endtask

    task automatic chk_dut(input int sel, input string tag, input int out, input logic err, input logic tc);
        n_vec++;
        if (sel == 0) begin
            chk(tag, "sat.out", int'(s_out), out);
            chk(tag, "sat.err", int'(s_err), int'(err));
            chk(tag, "sat.tc",  int'(s_tc),  int'(tc));
        end else begin
            chk(tag, "wrap.out", int'(w_out), out);
            chk(tag, "wrap.err", int'(w_err), int'(err));
            chk(tag, "wrap.tc",  int'(w_tc),  int'(tc));
        end
    endtask

    // Drive one vector at the falling edge, sample 1 time unit after the rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        if (v.sel == 0) begin
            s_en = v.en; s_dir = v.dir; s_load = v.load; s_step = v.step; s_data = v.data;
            w_en = 1'b0;
        end else begin
            w_en = v.en; w_dir = v.dir; w_load = v.load; w_step = v.step; w_data = v.data;
            s_en = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_dut(v.sel, tag, int'(v.out), v.err, v.tc);
    endtask

    initial begin
        // Saturating instance: sel en dir load step data | out err tc
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1,  0,  1, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b1, 0,  9,  9, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b1, 0, 13, 15, 1'b1, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1,  0, 15, 1'b1, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b0, 3,  0, 15, 1'b1, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b1, 0,  3,  3, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b0, 3,  0,  0, 1'b0, 1'b1));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b0, 1,  0,  0, 1'b0, 1'b1));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b0, 0,  0,  0, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b1, 0, 11, 11, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 3,  0, 12, 1'b0, 1'b1));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 3,  0, 12, 1'b0, 1'b1));
        tbl.push_back(mk(0, 1'b0, 1'b1, 1'b0, 3,  0, 12, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 0,  0, 12, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b0, 2,  0, 10, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 2,  0, 12, 1'b0, 1'b1));
        tbl.push_back(mk(0, 1'b0, 1'b1, 1'b1, 0,  5, 12, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b1, 2,  5,  5, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b1, 0, 12, 12, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b1, 0, 63, 15, 1'b1, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b1, 0, 14, 15, 1'b1, 1'b0));
        tbl.push_back(mk(0, 1'b0, 1'b0, 1'b1, 0,  3, 15, 1'b1, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b1, 0,  0,  0, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b0, 3,  0,  3, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 1'b0, 2,  0,  1, 1'b0, 1'b0));
        // Wrapping instance
        tbl.push_back(mk(1, 1'b1, 1'b0, 1'b1, 0, 11, 11, 1'b0, 1'b0));
        tbl.push_back(mk(1, 1'b1, 1'b1, 1'b0, 3,  0,  1, 1'b0, 1'b1));
        tbl.push_back(mk(1, 1'b1, 1'b0, 1'b0, 2,  0, 12, 1'b0, 1'b1));
        tbl.push_back(mk(1, 1'b1, 1'b0, 1'b0, 1,  0, 11, 1'b0, 1'b0));
        tbl.push_back(mk(1, 1'b1, 1'b1, 1'b0, 1,  0, 12, 1'b0, 1'b1));
        tbl.push_back(mk(1, 1'b1, 1'b1, 1'b0, 0,  0, 12, 1'b0, 1'b0));
        tbl.push_back(mk(1, 1'b1, 1'b1, 1'b0, 2,  0,  1, 1'b0, 1'b1));
        tbl.push_back(mk(1, 1'b1, 1'b1, 1'b1, 0, 13, 15, 1'b1, 1'b0));
        tbl.push_back(mk(1, 1'b1, 1'b1, 1'b0, 1,  0, 15, 1'b1, 1'b0));
        tbl.push_back(mk(1, 1'b1, 1'b0, 1'b1, 0,  0,  0, 1'b0, 1'b0));
        tbl.push_back(mk(1, 1'b1, 1'b0, 1'b0, 1,  0, 12, 1'b0, 1'b1));
        tbl.push_back(mk(1, 1'b1, 1'b0, 1'b0, 3,  0,  9, 1'b0, 1'b0));
        tbl.push_back(mk(1, 1'b0, 1'b0, 1'b1, 0,  2,  9, 1'b0, 1'b0));

        // Reset state, checked before the first clock edge.
        #2;
        chk_dut(0, "reset", 0, 1'b0, 1'b0);
        chk_dut(1, "reset", 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-operation, with the saturating DUT in ERROR.
        run_vec(mk(0, 1'b1, 1'b0, 1'b1, 0, 63, 15, 1'b1, 1'b0), "pre_rst_err");
        run_vec(mk(1, 1'b1, 1'b0, 1'b1, 0,  7,  7, 1'b0, 1'b0), "pre_rst_load");
        @(negedge clk);
        s_en = 1'b1; s_dir = 1'b1; s_load = 1'b0; s_step = 2'd1;
        w_en = 1'b1; w_dir = 1'b1; w_load = 1'b0; w_step = 2'd1;
        #2;
        rst = 1'b1;
        #1;
        chk_dut(0, "rst_async", 0, 1'b0, 1'b0);
        chk_dut(1, "rst_async", 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_dut(0, "rst_held", 0, 1'b0, 1'b0);
        chk_dut(1, "rst_held", 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        s_en = 1'b0;
        w_en = 1'b0;
        run_vec(mk(0, 1'b1, 1'b1, 1'b0, 1, 0, 1, 1'b0, 1'b0), "post_rst_sat");
        run_vec(mk(1, 1'b1, 1'b1, 1'b0, 1, 0, 1, 1'b0, 1'b0), "post_rst_wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Watchdog so the run can never hang.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
